// File: rtl/mult_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// FSM encoding, iteration count and Booth window codes.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } mult_state_t;

  localparam int MULT_STEPS = 16;

  // {Q[1], Q[0], q-1} windows
  localparam logic [2:0] BD_Z0  = 3'b000;
  localparam logic [2:0] BD_P1A = 3'b001;
  localparam logic [2:0] BD_P1B = 3'b010;
  localparam logic [2:0] BD_P2  = 3'b011;
  localparam logic [2:0] BD_N2  = 3'b100;
  localparam logic [2:0] BD_N1A = 3'b101;
  localparam logic [2:0] BD_N1B = 3'b110;
  localparam logic [2:0] BD_Z1  = 3'b111;

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth digit selector: maps a 3-bit window to
// the addend 0, +-M or +-2M in 34-bit two's complement.
module booth_recode
  import mult_pkg::*;
#(
  parameter int AW = 34
) (
  input  logic [2:0]    win_i,
  input  logic [AW-1:0] m_i,
  output logic [AW-1:0] addend_o
);

  logic [AW-1:0] m2;

  assign m2 = {m_i[AW-2:0], 1'b0};

  always_comb begin
    addend_o = '0;
    unique case (win_i)
      BD_Z0, BD_Z1:   addend_o = '0;
      BD_P1A, BD_P1B: addend_o = m_i;
      BD_P2:          addend_o = m2;
      BD_N2:          addend_o = -m2;
      BD_N1A, BD_N1B: addend_o = -m_i;
      default:        addend_o = '0;
    endcase
  end

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential signed 32x32 radix-4 Booth multiplier, one digit
// per cycle, with registered 64-bit product and overflow flag.
module mult_booth_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ctrl_MULT,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic [WIDTH-1:0]   data_result,
  output logic [2*WIDTH-1:0] data_product,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy
);

  localparam int AW  = WIDTH + 2;
  localparam int ACC = AW + WIDTH + 1;

  if (WIDTH != 32) begin : g_bad_width
    $error("mult_booth_seq: only WIDTH=32 is supported");
  end
  if (STEPS != MULT_STEPS || STEPS != WIDTH / 2) begin : g_bad_steps
    $error("mult_booth_seq: STEPS must equal WIDTH/2");
  end

  mult_state_t      state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ACC-1:0]   acc_q, acc_d;
  logic [AW-1:0]    m_q, m_d;
  logic [2*WIDTH-1:0] prod_q;
  logic             exc_q;

  logic [AW-1:0]      addend;
  logic [AW-1:0]      u_sum;
  logic [ACC-1:0]     acc_shift;
  logic [2*WIDTH-1:0] prod_next;
  logic               exc_next;
  logic               load_out;
  logic               last;

  booth_recode #(
    .AW(AW)
  ) u_recode (
    .win_i   (acc_q[2:0]),
    .m_i     (m_q),
    .addend_o(addend)
  );

  // Accumulator layout: {U[33:0], Q[31:0], q-1}
  assign u_sum     = acc_q[ACC-1 -: AW] + addend;
  assign acc_shift = {{2{u_sum[AW-1]}}, u_sum, acc_q[WIDTH:2]};

  // {U[31:0], Q} after the shift, taken straight from the sum
  assign prod_next = {u_sum, acc_q[WIDTH:3]};
  assign exc_next  =
    |(prod_next[2*WIDTH-1:WIDTH] ^ {WIDTH{prod_next[WIDTH-1]}});

  assign last = (cnt_q == 4'(STEPS - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    m_d      = m_q;
    load_out = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (ctrl_MULT) begin
          m_d     = {{2{data_operandA[WIDTH-1]}}, data_operandA};
          acc_d   = {{AW{1'b0}}, data_operandB, 1'b0};
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_shift;
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          state_d  = S_DONE;
          load_out = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prod_q <= '0;
      exc_q  <= 1'b0;
    end else if (load_out) begin
      prod_q <= prod_next;
      exc_q  <= exc_next;
    end
  end

  assign data_product   = prod_q;
  assign data_result    = prod_q[WIDTH-1:0];
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == S_DONE);
  assign busy           = (state_q == S_RUN);

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed and randomized checks of mult_booth_seq against
// hand-computed vectors and a 64-bit signed product model.
module tb_mult_booth_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic [63:0] data_product;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  mult_booth_seq #(
    .WIDTH(32),
    .STEPS(16)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_MULT     (ctrl_MULT),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_product  (data_product),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a,
                       input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    chk("busy_run", 64'(busy), 64'd1);
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (data_resultRDY) break;
    end
    chk("rdy_seen", 64'(data_resultRDY), 64'd1);
  endtask

  task automatic op(input string tag,
                    input logic [31:0] a,
                    input logic [31:0] b,
                    input logic [63:0] ep,
                    input logic        ee);
    int cyc;
    start(a, b);
    wait_rdy(cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'd16);
    chk({tag, "_prod"}, data_product, ep);
    chk({tag, "_res"}, 64'(data_result), 64'(ep[31:0]));
    chk({tag, "_exc"}, 64'(data_exception), 64'(ee));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic        e;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cyc;
    int rdy_cnt;
    logic [31:0] ra, rb;
    int ia, ib;
    longint rp;
    logic [63:0] up;
    logic re;

    vecs.push_back('{32'd3, 32'd5, 64'd15, 1'b0});
    vecs.push_back('{32'hFFFF_FFF9, 32'd6,
                     64'hFFFF_FFFF_FFFF_FFD6, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'd2,
                     64'h0000_0000_FFFF_FFFE, 1'b1});
    vecs.push_back('{32'h0001_0000, 32'h0001_0000,
                     64'h0000_0001_0000_0000, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF,
                     64'h0000_0000_8000_0000, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'd1,
                     64'hFFFF_FFFF_8000_0000, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF,
                     64'd1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF,
                     64'h3FFF_FFFF_0000_0001, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000,
                     64'h4000_0000_0000_0000, 1'b1});
    vecs.push_back('{32'd0, 32'h1234_5678, 64'd0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd2,
                     64'hFFFF_FFFF_FFFF_FFFE, 1'b0});

    #2 reset_n = 1'b0;
    #1;
    chk("rst_prod", data_product, 64'd0);
    chk("rst_res", 64'(data_result), 64'd0);
    chk("rst_exc", 64'(data_exception), 64'd0);
    chk("rst_rdy", 64'(data_resultRDY), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    foreach (vecs[i])
      op($sformatf("v%0d", i), vecs[i].a, vecs[i].b,
         vecs[i].p, vecs[i].e);

    @(posedge clock);
    #1;
    chk("idle_rdy", 64'(data_resultRDY), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_hold", data_product, 64'hFFFF_FFFF_FFFF_FFFE);

    start(32'd3, 32'd5);
    repeat (5) @(posedge clock);
    #1;
    data_operandA = 32'd100;
    data_operandB = 32'd100;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    wait_rdy(cyc);
    chk("ign_lat", 64'(cyc), 64'd10);
    chk("ign_prod", data_product, 64'd15);

    op("b2b", 32'hFFFF_FFF9, 32'hFFFF_FFF9, 64'd49, 1'b0);

    start(32'd1000, 32'd1000);
    repeat (8) @(posedge clock);
    #3;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_prod", data_product, 64'd0);
    chk("arst_res", 64'(data_result), 64'd0);
    chk("arst_exc", 64'(data_exception), 64'd0);
    chk("arst_rdy", 64'(data_resultRDY), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_cnt++;
    end
    chk("no_rdy", 64'(rdy_cnt), 64'd0);
    op("post_rst", 32'd2, 32'd2, 64'd4, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k % 8 == 0) ra = {ra[31], 31'h0};
      if (k % 8 == 1) rb = {32{rb[0]}};
      ia = ra;
      ib = rb;
      rp = longint'(ia) * longint'(ib);
      up = rp;
      re = (up[63:32] != {32{up[31]}});
      op("rand", ra, rb, up, re);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
